itoa_tx_stream: RTL

ITOA_TX_STREAM -- requirements
Module: itoa_tx_stream

---
 rtl/itoa_tx_stream.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/itoa_tx_stream.sv
// rtl/itoa_tx_stream.sv - streams an itoa32 decimal result as bytes with optional terminator
//
// Purpose: handshakes with an external itoa32 converter (load pulse / done flag),
// captures its ten ASCII digits and sends them MSB first over a valid/ready byte
// stream, stripping or blanking leading zeros, optionally followed by a terminator.
//
// Ports:
//   clk        - single clock, all state on rising edge
//   reset      - asynchronous active-low reset
//   start      - one-cycle request to convert and send the current value
//   busy       - high from accepted start until the final byte is transferred
//   itoa_load  - one-cycle load pulse to itoa32
//   itoa_done  - itoa32 done flag
//   CHAR9..0   - itoa32 ASCII digits, CHAR9 most significant
//   tx_data    - byte to downstream sink
//   tx_valid   - tx_data valid
//   tx_ready   - sink accepts byte when tx_valid and tx_ready are both high
//   tx_last    - high with the final byte of the string
module itoa_tx_stream #(
  parameter bit         TERM_EN   = 1'b1,
  parameter logic [7:0] TERM_CHAR = 8'h0D,
  parameter bit         LZ_MODE   = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       itoa_load,
  input  logic       itoa_done,
  input  logic [7:0] CHAR9,
  input  logic [7:0] CHAR8,
  input  logic [7:0] CHAR7,
  input  logic [7:0] CHAR6,
  input  logic [7:0] CHAR5,
  input  logic [7:0] CHAR4,
  input  logic [7:0] CHAR3,
  input  logic [7:0] CHAR2,
  input  logic [7:0] CHAR1,
  input  logic [7:0] CHAR0,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       tx_last
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    GAP,
    WAIT,
    SEND,
    TERM
  } state_t;

  state_t     r_state;
  logic [7:0] r_dig [10];
  logic [3:0] r_msd;
  logic [3:0] r_idx;
  logic       r_busy;
  logic       r_itoa_load;
  logic [7:0] r_tx_data;
  logic       r_tx_valid;
  logic       r_tx_last;

  logic [7:0] w_char [10];
  logic [3:0] w_msd;
  logic [3:0] w_start_idx;
  logic [3:0] w_idx_dec;
  logic       w_xfer;

  assign w_char[0] = CHAR0;
  assign w_char[1] = CHAR1;
  assign w_char[2] = CHAR2;
  assign w_char[3] = CHAR3;
  assign w_char[4] = CHAR4;
  assign w_char[5] = CHAR5;
  assign w_char[6] = CHAR6;
  assign w_char[7] = CHAR7;
  assign w_char[8] = CHAR8;
  assign w_char[9] = CHAR9;

  // itoa32 may present an unused digit position either as '0' or as NUL.
  function automatic logic is_zero(input logic [7:0] d);
    return (d == 8'h30) || (d == 8'h00);
  endfunction

  // Byte to send for digit d at position j, given the most significant
  // non-zero position msd. Positions above msd only exist on the wire in
  // fixed-field mode, where they are blanked; msd is 0 for a zero value so
  // the units digit always shows.
  function automatic logic [7:0] fmt(input logic [7:0] d, input logic [3:0] j,
                                     input logic [3:0] msd);
    if (!is_zero(d)) begin
      return d;
    end else if (LZ_MODE && (j > msd)) begin
      return 8'h20;
    end else begin
      return 8'h30;
    end
  endfunction

  always_comb begin
    w_msd = 4'd0;
    for (int i = 1; i < 10; i++) begin
      if (!is_zero(w_char[i])) begin
        w_msd = 4'(i);
      end
    end
  end

  assign w_start_idx = LZ_MODE ? 4'd9 : w_msd;
  assign w_idx_dec   = r_idx - 4'd1;
  assign w_xfer      = r_tx_valid & tx_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_msd       <= 4'd0;
      r_idx       <= 4'd0;
      r_busy      <= 1'b0;
      r_itoa_load <= 1'b0;
      r_tx_data   <= 8'h00;
      r_tx_valid  <= 1'b0;
      r_tx_last   <= 1'b0;
      for (int i = 0; i < 10; i++) begin
        r_dig[i] <= 8'h00;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state     <= LOAD;
            r_busy      <= 1'b1;
            r_itoa_load <= 1'b1;
          end
        end

        LOAD: begin
          r_itoa_load <= 1'b0;
          r_state     <= GAP;
        end

        // The done flag is still high from the previous conversion here,
        // so it is not looked at until the converter has seen the load.
        GAP: begin
          r_state <= WAIT;
        end

        // First byte is formatted straight from the inputs so tx_valid
        // rises the cycle after done is sampled.
        WAIT: begin
          if (itoa_done) begin
            for (int i = 0; i < 10; i++) begin
              r_dig[i] <= w_char[i];
            end
            r_msd      <= w_msd;
            r_idx      <= w_start_idx;
            r_tx_valid <= 1'b1;
            r_tx_data  <= fmt(w_char[w_start_idx], w_start_idx, w_msd);
            r_tx_last  <= !TERM_EN && (w_start_idx == 4'd0);
            r_state    <= SEND;
          end
        end

        SEND: begin
          if (w_xfer) begin
            if (r_idx == 4'd0) begin
              if (TERM_EN) begin
                r_tx_data <= TERM_CHAR;
                r_tx_last <= 1'b1;
                r_state   <= TERM;
              end else begin
                r_tx_valid <= 1'b0;
                r_tx_last  <= 1'b0;
                r_busy     <= 1'b0;
                r_state    <= IDLE;
              end
            end else begin
              r_idx     <= w_idx_dec;
              r_tx_data <= fmt(r_dig[w_idx_dec], w_idx_dec, r_msd);
              r_tx_last <= !TERM_EN && (w_idx_dec == 4'd0);
            end
          end
        end

        TERM: begin
          if (w_xfer) begin
            r_tx_valid <= 1'b0;
            r_tx_last  <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign itoa_load = r_itoa_load;
  assign tx_data   = r_tx_data;
  assign tx_valid  = r_tx_valid;
  assign tx_last   = r_tx_last;

endmodule
